byte_unstriping: RTL and testbench

//  Receive-side counterpart of the phy_tx byte striper. Merges two byte lanes
//  (lane_0 = even bytes, lane_1 = odd bytes) back into one byte stream.

---
 rtl/byte_unstriping_pkg.sv | 14 +
 rtl/byte_unstriping_pair_fifo.sv | 46 ++++
 rtl/byte_unstriping.sv | 91 +++++++++
 tb/tb_byte_unstriping.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/byte_unstriping_pkg.sv
// Shared definitions for the receive-side byte unstriper.
package byte_unstriping_pkg;

   localparam int unsigned DEF_DATA_W     = 8;
   localparam int unsigned DEF_FIFO_DEPTH = 4;

   // Output sequencer states: nothing shown, even byte shown, odd byte shown
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND0 = 2'd1,
      ST_SEND1 = 2'd2
   } state_t;

endpackage

// File: rtl/byte_unstriping_pair_fifo.sv
// Synchronous FIFO holding {lane_1, lane_0} pairs; pointers carry one extra wrap bit.
module byte_unstriping_pair_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rptr[AW-1:0]];

   // Pointer update; wrap bit distinguishes full from empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage write; contents are only read while the FIFO is non-empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/byte_unstriping.sv
// Merges even/odd byte lanes back into one byte stream through a pair FIFO.
module byte_unstriping
   import byte_unstriping_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk_2f,
   input  logic              reset,
   input  logic              valid_0,
   input  logic [DATA_W-1:0] lane_0,
   input  logic              valid_1,
   input  logic [DATA_W-1:0] lane_1,
   output logic              ready_out,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   output logic              align_err,
   output logic              fifo_full,
   output logic              fifo_empty
);

   state_t              state;
   logic                push;
   logic                pop;
   logic [2*DATA_W-1:0] head;

   assign ready_out = !fifo_full;
   assign push      = valid_0 && valid_1 && ready_out;
   // Head is retired on the edge that moves its odd byte onto data_out
   assign pop       = (state == ST_SEND0);

   byte_unstriping_pair_fifo #(
      .WIDTH (2*DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_2f),
      .rst_n (reset),
      .push  (push),
      .wdata ({lane_1, lane_0}),
      .pop   (pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Lanes disagreeing on valid while a pair could be taken: flag for one cycle
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) align_err <= 1'b0;
      else        align_err <= (valid_0 ^ valid_1) && ready_out;
   end

   // Output sequencer: even byte, then odd byte, back-to-back while data remains
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         valid_out <= 1'b0;
         data_out  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state     <= ST_SEND0;
                  valid_out <= 1'b1;
                  data_out  <= head[DATA_W-1:0];
               end
            end
            ST_SEND0: begin
               state    <= ST_SEND1;
               data_out <= head[2*DATA_W-1:DATA_W];
            end
            ST_SEND1: begin
               if (!fifo_empty) begin
                  state     <= ST_SEND0;
                  valid_out <= 1'b1;
                  data_out  <= head[DATA_W-1:0];
               end else begin
                  state     <= ST_IDLE;
                  valid_out <= 1'b0;
                  data_out  <= '0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               valid_out <= 1'b0;
               data_out  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_byte_unstriping.sv
// Randomized and directed bench for byte_unstriping against a queue-based model.
module tb_byte_unstriping;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;

   logic          clk_2f = 1'b0;
   logic          reset;
   logic          valid_0, valid_1;
   logic [DW-1:0] lane_0, lane_1;
   logic          ready_out, valid_out, align_err, fifo_full, fifo_empty;
   logic [DW-1:0] data_out;

   byte_unstriping #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk_2f     (clk_2f),
      .reset      (reset),
      .valid_0    (valid_0),
      .lane_0     (lane_0),
      .valid_1    (valid_1),
      .lane_1     (lane_1),
      .ready_out  (ready_out),
      .valid_out  (valid_out),
      .data_out   (data_out),
      .align_err  (align_err),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty)
   );

   always #5 clk_2f = ~clk_2f;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Reference: stored pairs in arrival order, plus the byte currently on the output
   logic [2*DW-1:0] pq[$];
   bit              even_shown;   // head pair's even byte is on the output now
   logic            exp_v;
   logic [DW-1:0]   exp_d;
   logic            exp_align;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_clear();
      pq.delete();
      even_shown = 1'b0;
      exp_v      = 1'b0;
      exp_d      = '0;
      exp_align  = 1'b0;
   endfunction

   // One clock edge of the reference, from pre-edge occupancy and current inputs
   function automatic void model_edge(bit v0, bit [DW-1:0] l0, bit v1, bit [DW-1:0] l1);
      bit was_full;
      bit was_empty;
      was_full  = (pq.size() == DEPTH);
      was_empty = (pq.size() == 0);
      exp_align = (v0 != v1) && !was_full;
      if (even_shown) begin
         exp_v = 1'b1;
         exp_d = pq[0][2*DW-1:DW];
         void'(pq.pop_front());
         even_shown = 1'b0;
      end else if (!was_empty) begin
         exp_v = 1'b1;
         exp_d = pq[0][DW-1:0];
         even_shown = 1'b1;
      end else begin
         exp_v = 1'b0;
         exp_d = '0;
      end
      if (v0 && v1 && !was_full) pq.push_back({l1, l0});
   endfunction

   task automatic check_all(input string where);
      chk({where, ".valid_out"},  16'(valid_out),  16'(exp_v));
      chk({where, ".data_out"},   16'(data_out),   16'(exp_d));
      chk({where, ".align_err"},  16'(align_err),  16'(exp_align));
      chk({where, ".fifo_full"},  16'(fifo_full),  16'(pq.size() == DEPTH));
      chk({where, ".fifo_empty"}, 16'(fifo_empty), 16'(pq.size() == 0));
      chk({where, ".ready_out"},  16'(ready_out),  16'(pq.size() != DEPTH));
   endtask

   // Drive inputs for one cycle (called at negedge), then check after the edge
   task automatic step(input bit v0, input bit [DW-1:0] l0, input bit v1,
                       input bit [DW-1:0] l1, input string where);
      valid_0 = v0; lane_0 = l0; valid_1 = v1; lane_1 = l1;
      @(posedge clk_2f);
      model_edge(v0, l0, v1, l1);
      @(negedge clk_2f);
      check_all(where);
   endtask

   task automatic idle(input int n, input string where);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, where);
   endtask

   // Present a pair, re-presenting it while the FIFO is full
   task automatic send_pair(input bit [DW-1:0] l0, input bit [DW-1:0] l1, input string where);
      int tries;
      bit accepted;
      tries = 0;
      accepted = 1'b0;
      while (!accepted && tries < 20) begin
         accepted = (pq.size() != DEPTH);
         step(1'b1, l0, 1'b1, l1, where);
         tries++;
      end
      chk({where, ".accept_timeout"}, 16'(accepted), 16'(1));
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once
   task automatic pulse_reset(input string where);
      reset = 1'b0;
      #1;
      model_clear();
      check_all({where, ".async"});
      @(negedge clk_2f);
      check_all({where, ".held"});
      reset = 1'b1;
   endtask

   initial begin
      bit [DW-1:0] p0 [6];
      bit [DW-1:0] p1 [6];
      p0 = '{8'hFF, 8'hDD, 8'h03, 8'h07, 8'h11, 8'h33};
      p1 = '{8'hEE, 8'hCC, 8'h04, 8'h08, 8'h22, 8'h44};

      reset = 1'b0;
      valid_0 = 1'b0; valid_1 = 1'b0; lane_0 = '0; lane_1 = '0;
      model_clear();
      repeat (2) @(negedge clk_2f);
      check_all("reset_hold");
      reset = 1'b1;

      // Single pair: even byte after k+1, odd after k+2, idle after k+3
      step(1'b1, 8'hFF, 1'b1, 8'hEE, "single.push");
      chk("single.k+0_empty", 16'(fifo_empty), 16'(0));
      idle(1, "single.k1");
      chk("single.k1_byte", 16'(data_out), 16'(8'hFF));
      idle(1, "single.k2");
      chk("single.k2_byte", 16'(data_out), 16'(8'hEE));
      idle(1, "single.k3");
      chk("single.k3_valid", 16'(valid_out), 16'(0));

      // Back-to-back pairs overrun depth 4 and get back-pressured
      for (int i = 0; i < 6; i++) send_pair(p0[i], p1[i], "burst");
      idle(14, "burst.drain");

      // Lane misalignment: dropped pair, one-cycle flag
      step(1'b1, 8'hAA, 1'b0, 8'h00, "align.err");
      chk("align.pulse", 16'(align_err), 16'(1));
      idle(1, "align.after");
      chk("align.cleared", 16'(align_err), 16'(0));
      idle(2, "align.tail");

      // Reset while the odd byte of 03/04 is on the output
      step(1'b1, 8'h03, 1'b1, 8'h04, "rst.push");
      idle(2, "rst.wait");
      chk("rst.odd_shown", 16'(data_out), 16'(8'h04));
      pulse_reset("rst.mid");
      step(1'b1, 8'h07, 1'b1, 8'h08, "rst.next");
      idle(4, "rst.next_drain");

      // Fill, then simultaneous push and pop, then run past pointer wrap
      for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h40 + i), 1'b1, DW'(8'h50 + i), "pp.fill");
      for (int i = 0; i < 12; i++) send_pair(DW'(8'h60 + i), DW'(8'h70 + i), "wrap");
      idle(30, "wrap.drain");

      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         int unsigned r;
         r = $urandom_range(0, 99);
         if (r < 1) begin
            pulse_reset("rnd.reset");
         end else if (r < 55) begin
            step(1'b1, DW'($urandom), 1'b1, DW'($urandom), "rnd.pair");
         end else if (r < 63) begin
            step(1'b1, DW'($urandom), 1'b0, DW'($urandom), "rnd.mis0");
         end else if (r < 70) begin
            step(1'b0, DW'($urandom), 1'b1, DW'($urandom), "rnd.mis1");
         end else begin
            step(1'b0, DW'($urandom), 1'b0, DW'($urandom), "rnd.idle");
         end
      end
      idle(12, "final.drain");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
